// File: rtl/centroid_marker_pkg.sv
// Shared video constants and helpers for the centroid marker overlay.
// Coordinate, pixel and distance widths plus default geometry and colour.
package centroid_marker_pkg;

    localparam int COORD_W = 10;
    localparam int PIX_W   = 24;
    localparam int DIST_W  = 11;

    localparam int IMG_W_DEF = 720;
    localparam int IMG_H_DEF = 576;

    localparam logic [PIX_W-1:0] MARK_COLOR_DEF = 24'hFF0000;

    // Unsigned distance between two coordinates, one bit wider than them.
    function automatic logic [DIST_W-1:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [DIST_W-1:0] ea;
        logic [DIST_W-1:0] eb;
        ea = {{(DIST_W-COORD_W){1'b0}}, a};
        eb = {{(DIST_W-COORD_W){1'b0}}, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/centroid_marker_hit.sv
// Marker geometry: cross of half-length ARM plus square ring at BOX.
// Purely combinational on column/row distance from the centroid.
module centroid_marker_hit
    import centroid_marker_pkg::*;
#(
    parameter int ARM = 8,
    parameter int BOX = 12
) (
    input  logic [DIST_W-1:0] dc,
    input  logic [DIST_W-1:0] dr,
    output logic              hit
);

    localparam logic [DIST_W-1:0] ARM_D = DIST_W'(ARM);
    localparam logic [DIST_W-1:0] BOX_D = DIST_W'(BOX);

    logic [DIST_W-1:0] dmax;
    logic              on_row;
    logic              on_col;
    logic              on_box;

    // Horizontal arm, vertical arm and the Chebyshev ring.
    always_comb begin
        dmax   = (dc > dr) ? dc : dr;
        on_row = (dr == '0) && (dc <= ARM_D);
        on_col = (dc == '0) && (dr <= ARM_D);
        on_box = (dmax == BOX_D);
        hit    = on_row | on_col | on_box;
    end

endmodule

// File: rtl/delay_line.sv
// Generic N-bit wide, DELAY-deep shift register with clock enable.
// Synchronous active-high reset flushes every stage to zero.
module delay_line #(
    parameter int DELAY = 2,
    parameter int N     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] pipe [DELAY];

    // Shift the word one stage per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe[i] <= '0;
            end
        end else if (ce) begin
            pipe[0] <= d;
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DELAY-1];

endmodule

// File: rtl/centroid_marker.sv
// Overlays a cross and square ring at the frame's centroid position.
// Two-stage pass-through; coordinates latched on the first active pixel.
module centroid_marker
    import centroid_marker_pkg::*;
#(
    parameter int               IMG_W      = IMG_W_DEF,
    parameter int               IMG_H      = IMG_H_DEF,
    parameter int               ARM        = 8,
    parameter int               BOX        = 12,
    parameter logic [PIX_W-1:0] MARK_COLOR = MARK_COLOR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               en,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [PIX_W-1:0]   rgb_in,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [PIX_W-1:0]   rgb_out
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 1);

    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               armed;

    logic [COORD_W-1:0] mx;
    logic [COORD_W-1:0] my;
    logic               show;

    logic               fs;
    logic [COORD_W-1:0] x_clamp;
    logic [COORD_W-1:0] y_clamp;
    logic [COORD_W-1:0] mx_cur;
    logic [COORD_W-1:0] my_cur;
    logic               show_cur;

    logic [DIST_W-1:0]  dc_s1;
    logic [DIST_W-1:0]  dr_s1;
    logic               show_s1;
    logic               de_s1;
    logic [PIX_W-1:0]   rgb_s1;
    logic               geo_hit;

    // Frame-start detect, clamped coordinates and the marker in force now.
    always_comb begin
        fs       = armed & de_in & (col == '0) & (row == '0);
        x_clamp  = (x > COL_LAST) ? COL_LAST : x;
        y_clamp  = (y > ROW_LAST) ? ROW_LAST : y;
        mx_cur   = fs ? x_clamp : mx;
        my_cur   = fs ? y_clamp : my;
        show_cur = fs ? (en & ~((x == '0) & (y == '0))) : show;
    end

    // Raster position; idle after reset until vertical blanking is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            col   <= '0;
            row   <= '0;
            armed <= 1'b0;
        end else if (ce) begin
            if (!vsync_in) begin
                col   <= '0;
                row   <= '0;
                armed <= 1'b1;
            end else if (armed && de_in) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Latch centroid and visibility once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            mx   <= '0;
            my   <= '0;
            show <= 1'b0;
        end else if (ce && fs) begin
            mx   <= x_clamp;
            my   <= y_clamp;
            show <= show_cur;
        end
    end

    // Stage 1: distances from the centroid alongside the pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_s1   <= '0;
            dr_s1   <= '0;
            show_s1 <= 1'b0;
            de_s1   <= 1'b0;
            rgb_s1  <= '0;
        end else if (ce) begin
            dc_s1   <= abs_diff(col, mx_cur);
            dr_s1   <= abs_diff(row, my_cur);
            show_s1 <= show_cur;
            de_s1   <= de_in;
            rgb_s1  <= rgb_in;
        end
    end

    centroid_marker_hit #(
        .ARM (ARM),
        .BOX (BOX)
    ) u_hit (
        .dc  (dc_s1),
        .dr  (dr_s1),
        .hit (geo_hit)
    );

    // Stage 2: paint marker pixels, pass everything else through.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out <= '0;
        end else if (ce) begin
            rgb_out <= (geo_hit & show_s1 & de_s1) ? MARK_COLOR : rgb_s1;
        end
    end

    delay_line #(
        .DELAY (2),
        .N     (3)
    ) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d   ({de_in, hsync_in, vsync_in}),
        .q   ({de_out, hsync_out, vsync_out})
    );

endmodule

// File: tb/tb_centroid_marker.sv
// Scoreboard bench for centroid_marker on a 16x12 raster.
// Stimulus pushes expected outputs; a monitor pops and compares.
module tb_centroid_marker;

    localparam int W   = 16;
    localparam int H   = 12;
    localparam int ARM = 2;
    localparam int BOX = 3;
    localparam logic [23:0] RED = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        en;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [23:0] rgb_in;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic [23:0] rgb_out;

    typedef logic [26:0] item_t;

    item_t q[$];
    item_t last_exp;
    int    n_chk   = 0;
    int    n_fail  = 0;
    int    red_cnt = 0;

    int m_col, m_row, m_mx, m_my;
    bit m_show, m_armed;

    always #5 clk = ~clk;

    centroid_marker #(
        .IMG_W      (W),
        .IMG_H      (H),
        .ARM        (ARM),
        .BOX        (BOX),
        .MARK_COLOR (RED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .en        (en),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .rgb_in    (rgb_in),
        .x         (x),
        .y         (y),
        .de_out    (de_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .rgb_out   (rgb_out)
    );

    task automatic check(input string nm, input item_t got, input item_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h exp %h", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_col   = 0;
        m_row   = 0;
        m_mx    = 0;
        m_my    = 0;
        m_show  = 0;
        m_armed = 0;
    endtask

    task automatic model_push();
        bit fs, sh, hit;
        int mxe, mye, dc, dr, dm;
        fs  = m_armed && de_in && m_col == 0 && m_row == 0;
        mxe = fs ? ((int'(x) > W - 1) ? W - 1 : int'(x)) : m_mx;
        mye = fs ? ((int'(y) > H - 1) ? H - 1 : int'(y)) : m_my;
        sh  = fs ? (en && !(x == 0 && y == 0)) : m_show;
        if (fs) begin
            m_mx   = mxe;
            m_my   = mye;
            m_show = sh;
        end
        dc  = (m_col > mxe) ? m_col - mxe : mxe - m_col;
        dr  = (m_row > mye) ? m_row - mye : mye - m_row;
        dm  = (dc > dr) ? dc : dr;
        hit = sh && de_in &&
              ((dr == 0 && dc <= ARM) || (dc == 0 && dr <= ARM) || dm == BOX);
        q.push_back({de_in, hsync_in, vsync_in, hit ? RED : rgb_in});
        if (!vsync_in) begin
            m_col   = 0;
            m_row   = 0;
            m_armed = 1;
        end else if (m_armed && de_in) begin
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic step(input logic d, input logic h, input logic v,
                        input logic [23:0] p);
        @(negedge clk);
        rst      = 1'b0;
        ce       = 1'b1;
        de_in    = d;
        hsync_in = h;
        vsync_in = v;
        rgb_in   = p;
        model_push();
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ce     = 1'b0;
            rgb_in = 24'h5A5A5A ^ 24'(i);
            de_in  = ~de_in;
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst   = 1'b1;
        ce    = 1'b1;
        de_in = 1'b0;
        model_reset();
    endtask

    task automatic frame(input int cx, input int cy, input bit en0,
                         input int chg_row, input int nx, input int ny,
                         input int en_row, input int stall_row,
                         input int rst_row, input bit pat,
                         input int exp_red, input string nm);
        x  = 10'(cx);
        y  = 10'(cy);
        en = en0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 24'h0);
        for (int r = 0; r < H; r++) begin
            if (r == chg_row) begin
                x = 10'(nx);
                y = 10'(ny);
            end
            if (r == en_row) en = 1'b1;
            if (r == rst_row) pulse_rst();
            for (int c = 0; c < W; c++) begin
                if (r == stall_row && c == 5) stall(5);
                step(1'b1, 1'b0, 1'b1, pat ? {8'h00, 8'(c), 8'(r)} : 24'h0);
            end
            repeat (2) step(1'b0, 1'b1, 1'b1, 24'h0);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 24'h0);
        n_chk++;
        if (red_cnt != exp_red) begin
            n_fail++;
            $display("FAIL %s marker_pixels got %0d exp %0d", nm, red_cnt, exp_red);
        end
        red_cnt = 0;
    endtask

    // Monitor: one expected word leaves the pipe per enabled edge.
    initial begin
        bit s_rst, s_ce;
        item_t got;
        last_exp = '0;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_ce  = ce;
            #1;
            got = {de_out, hsync_out, vsync_out, rgb_out};
            if (s_rst) begin
                q.delete();
                q.push_back('0);
                last_exp = '0;
                check("rst", got, last_exp);
            end else if (s_ce) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL underflow t=%0t got %h exp queued", $time, got);
                end else begin
                    last_exp = q.pop_front();
                    check("pix", got, last_exp);
                end
                if (de_out && rgb_out == RED) red_cnt++;
            end else begin
                check("hold", got, last_exp);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        ce       = 1'b0;
        en       = 1'b0;
        de_in    = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        rgb_in   = '0;
        x        = '0;
        y        = '0;
        model_reset();
        repeat (3) @(negedge clk);

        frame(8, 6, 1, -1, 0, 0, -1, -1, -1, 0, 33, "cross_box");
        frame(0, 0, 1, -1, 0, 0, -1, -1, -1, 1, 0, "no_object");
        frame(8, 6, 0, -1, 0, 0, 4, -1, -1, 0, 0, "disabled");
        frame(8, 6, 1, -1, 0, 0, -1, -1, -1, 0, 33, "reenabled");
        frame(20, 1, 1, -1, 0, 0, -1, -1, -1, 0, 14, "clip_clamp");
        frame(8, 6, 1, 5, 3, 3, -1, -1, -1, 0, 33, "mid_change");
        frame(3, 3, 1, -1, 0, 0, -1, -1, -1, 0, 33, "next_frame");
        frame(8, 6, 1, -1, 0, 0, -1, 6, -1, 1, 33, "stall");
        frame(8, 6, 1, -1, 0, 0, -1, -1, 5, 0, 10, "mid_rst");
        frame(8, 6, 1, -1, 0, 0, -1, -1, -1, 0, 33, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
